// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RISC-V
// size/sign codes, and the byte-lane mask and misalignment decoders.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    function automatic logic [7:0] size_mask(input logic [2:0] funct3);
        logic [7:0] mask;
        case (funct3[1:0])
            2'b00:   mask = 8'h01;
            2'b01:   mask = 8'h03;
            2'b10:   mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    // Code 111 has no defined size, so it is rejected the same way as a misaligned access.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
        logic bad;
        if (funct3 == 3'b111) begin
            bad = 1'b1;
        end else begin
            case (funct3[1:0])
                2'b00:   bad = 1'b0;
                2'b01:   bad = addr_lo[0];
                2'b10:   bad = |addr_lo[1:0];
                default: bad = |addr_lo;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: picks the addressed bytes out of an 8-byte
// aligned word and sign- or zero-extends them to XLEN.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = data >> {offset, 3'b000};
        result  = shifted;
        case (funct3)
            F3_B:    result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_W:    result = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            F3_BU:   result = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU:   result = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_WU:   result = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage between execute and the combinational memory model:
// sequences one op at a time through IDLE -> ACCESS -> DONE.
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [RD_W-1:0] in_rd,
    output logic [XLEN-1:0] mem_raddr,
    output logic            mem_ren,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] mem_waddr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    output logic            mem_wen,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic [RD_W-1:0] out_rd,
    output logic            out_misalign
);

    lsu_state_t      state, state_next;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [RD_W-1:0] rd_q;
    logic            is_load_q;
    logic            is_store_q;
    logic            misalign_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] aligned;
    logic            accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                funct3_q   <= in_funct3;
                addr_q     <= in_addr;
                wdata_q    <= in_wdata;
                rd_q       <= in_rd;
                is_load_q  <= in_is_load;
                is_store_q <= in_is_store;
                misalign_q <= (in_is_load || in_is_store) && is_misaligned(in_funct3, in_addr[2:0]);
            end
            if (mem_ren) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // Ops with no memory side skip ACCESS and report straight away.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (in_is_load || in_is_store) ? ACCESS : DONE;
                end
            end
            ACCESS: state_next = DONE;
            DONE: begin
                if (out_ready) begin
                    in_ready   = 1'b1;
                    state_next = IDLE;
                    if (in_valid) begin
                        state_next = (in_is_load || in_is_store) ? ACCESS : DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_ren   = (state == ACCESS) && is_load_q && !misalign_q;
    assign mem_wen   = (state == ACCESS) && is_store_q && !misalign_q;
    assign mem_wmask = mem_wen ? (size_mask(funct3_q) << addr_q[2:0]) : 8'h00;
    assign mem_raddr = {addr_q[XLEN-1:3], 3'b000};
    assign mem_waddr = {addr_q[XLEN-1:3], 3'b000};
    assign mem_wdata = wdata_q << {addr_q[2:0], 3'b000};

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .data   (rdata_q),
        .offset (addr_q[2:0]),
        .funct3 (funct3_q),
        .result (aligned)
    );

    assign out_valid    = (state == DONE);
    assign out_rdata    = (out_valid && is_load_q && !misalign_q) ? aligned : '0;
    assign out_rd       = rd_q;
    assign out_misalign = out_valid && misalign_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: each task walks one scenario cycle by cycle,
// sampling on the falling edge and comparing against hand-computed values.
module tb_lsu_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_is_load = 1'b0;
    logic        in_is_store = 1'b0;
    logic [2:0]  in_funct3 = 3'b000;
    logic [63:0] in_addr = '0;
    logic [63:0] in_wdata = '0;
    logic [4:0]  in_rd = '0;
    logic [63:0] mem_raddr;
    logic        mem_ren;
    logic [63:0] mem_rdata = '0;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_wen;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_misalign;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    lsu_stage #(.XLEN(64), .RD_W(5)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_is_load   (in_is_load),
        .in_is_store  (in_is_store),
        .in_funct3    (in_funct3),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_rd        (in_rd),
        .mem_raddr    (mem_raddr),
        .mem_ren      (mem_ren),
        .mem_rdata    (mem_rdata),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_wen      (mem_wen),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rdata    (out_rdata),
        .out_rd       (out_rd),
        .out_misalign (out_misalign)
    );

    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [63:0] a, input logic [63:0] wd, input logic [4:0] rd);
        in_valid    = 1'b1;
        in_is_load  = ld;
        in_is_store = st;
        in_funct3   = f3;
        in_addr     = a;
        in_wdata    = wd;
        in_rd       = rd;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%0h exp=0", out_valid); end
        checks++; if (mem_ren !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_ren got=%0h exp=0", mem_ren); end
        checks++; if (mem_wen !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_wen got=%0h exp=0", mem_wen); end
        checks++; if (mem_wmask !== 8'h00) begin failures++; $display("[TB] FAIL reset_mem_wmask got=%0h exp=0", mem_wmask); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%0h exp=1", in_ready); end
        checks++; if (out_rdata !== 64'h0) begin failures++; $display("[TB] FAIL reset_out_rdata got=%0h exp=0", out_rdata); end
        checks++; if (mem_waddr !== 64'h0) begin failures++; $display("[TB] FAIL reset_mem_waddr got=%0h exp=0", mem_waddr); end
        checks++; if (mem_wdata !== 64'h0) begin failures++; $display("[TB] FAIL reset_mem_wdata got=%0h exp=0", mem_wdata); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_store_byte();
        drive_op(1'b0, 1'b1, 3'b000, 64'h8000_0003, 64'h0000_0000_0000_00AB, 5'd1);
        @(negedge clock);
        in_valid = 1'b0;
        checks++; if (mem_wen !== 1'b1) begin failures++; $display("[TB] FAIL sb_wen got=%0h exp=1", mem_wen); end
        checks++; if (mem_waddr !== 64'h8000_0000) begin failures++; $display("[TB] FAIL sb_waddr got=%0h exp=80000000", mem_waddr); end
        checks++; if (mem_wmask !== 8'h08) begin failures++; $display("[TB] FAIL sb_wmask got=%0h exp=08", mem_wmask); end
        checks++; if (mem_wdata !== 64'h0000_0000_AB00_0000) begin failures++; $display("[TB] FAIL sb_wdata got=%0h exp=ab000000", mem_wdata); end
        checks++; if (mem_ren !== 1'b0) begin failures++; $display("[TB] FAIL sb_ren got=%0h exp=0", mem_ren); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL sb_early_valid got=%0h exp=0", out_valid); end
        @(negedge clock);
        checks++; if (mem_wen !== 1'b0) begin failures++; $display("[TB] FAIL sb_wen_one_cycle got=%0h exp=0", mem_wen); end
        checks++; if (mem_wmask !== 8'h00) begin failures++; $display("[TB] FAIL sb_wmask_done got=%0h exp=0", mem_wmask); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL sb_out_valid got=%0h exp=1", out_valid); end
        checks++; if (out_rdata !== 64'h0) begin failures++; $display("[TB] FAIL sb_out_rdata got=%0h exp=0", out_rdata); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL sb_back_idle got=%0h exp=0", out_valid); end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3 [6]  = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b110, 3'b101};
        logic [63:0] adr [6] = '{64'h8000_0005, 64'h8000_0005, 64'h8000_0002, 64'h8000_0004, 64'h8000_0004, 64'h8000_0002};
        logic [63:0] rd_w [6] = '{64'h0000_8000_0000_0000, 64'h0000_8000_0000_0000, 64'h0000_0000_F00D_0000,
                                  64'h89AB_CDEF_0000_0000, 64'h89AB_CDEF_0000_0000, 64'h0000_0000_F00D_0000};
        logic [63:0] exp [6] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080, 64'hFFFF_FFFF_FFFF_F00D,
                                 64'hFFFF_FFFF_89AB_CDEF, 64'h0000_0000_89AB_CDEF, 64'h0000_0000_0000_F00D};
        for (int i = 0; i < 6; i++) begin
            mem_rdata = rd_w[i];
            drive_op(1'b1, 1'b0, f3[i], adr[i], 64'h0, 5'd2);
            @(negedge clock);
            in_valid = 1'b0;
            checks++; if (mem_ren !== 1'b1) begin failures++; $display("[TB] FAIL load%0d_ren got=%0h exp=1", i, mem_ren); end
            checks++; if (mem_raddr !== 64'h8000_0000) begin failures++; $display("[TB] FAIL load%0d_raddr got=%0h exp=80000000", i, mem_raddr); end
            checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL load%0d_early_valid got=%0h exp=0", i, out_valid); end
            @(negedge clock);
            mem_rdata = 64'h0;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL load%0d_valid got=%0h exp=1", i, out_valid); end
            checks++; if (out_rdata !== exp[i]) begin failures++; $display("[TB] FAIL load%0d_rdata got=%0h exp=%0h", i, out_rdata, exp[i]); end
            @(negedge clock);
        end
    endtask

    task automatic test_load_double();
        mem_rdata = 64'h1122_3344_5566_7788;
        drive_op(1'b1, 1'b0, 3'b011, 64'h8000_0008, 64'h0, 5'd7);
        @(negedge clock);
        in_valid = 1'b0;
        checks++; if (mem_raddr !== 64'h8000_0008) begin failures++; $display("[TB] FAIL ld_raddr got=%0h exp=80000008", mem_raddr); end
        @(negedge clock);
        checks++; if (out_rdata !== 64'h1122_3344_5566_7788) begin failures++; $display("[TB] FAIL ld_rdata got=%0h exp=1122334455667788", out_rdata); end
        checks++; if (out_rd !== 5'd7) begin failures++; $display("[TB] FAIL ld_rd got=%0d exp=7", out_rd); end
        checks++; if (out_misalign !== 1'b0) begin failures++; $display("[TB] FAIL ld_misalign got=%0h exp=0", out_misalign); end
        @(negedge clock);
    endtask

    task automatic test_misaligned();
        logic        ld  [3] = '{1'b1, 1'b0, 1'b1};
        logic [2:0]  f3  [3] = '{3'b010, 3'b001, 3'b111};
        logic [63:0] adr [3] = '{64'h8000_0006, 64'h8000_0001, 64'h8000_0000};
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            drive_op(ld[i], !ld[i], f3[i], adr[i], 64'hFFFF, 5'd4);
            @(negedge clock);
            in_valid = 1'b0;
            checks++; if (mem_ren !== 1'b0) begin failures++; $display("[TB] FAIL mis%0d_ren got=%0h exp=0", i, mem_ren); end
            checks++; if (mem_wen !== 1'b0) begin failures++; $display("[TB] FAIL mis%0d_wen got=%0h exp=0", i, mem_wen); end
            checks++; if (mem_wmask !== 8'h00) begin failures++; $display("[TB] FAIL mis%0d_wmask got=%0h exp=0", i, mem_wmask); end
            @(negedge clock);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL mis%0d_valid got=%0h exp=1", i, out_valid); end
            checks++; if (out_misalign !== 1'b1) begin failures++; $display("[TB] FAIL mis%0d_flag got=%0h exp=1", i, out_misalign); end
            checks++; if (out_rdata !== 64'h0) begin failures++; $display("[TB] FAIL mis%0d_rdata got=%0h exp=0", i, out_rdata); end
            @(negedge clock);
        end
        mem_rdata = 64'h0;
    endtask

    task automatic test_no_op();
        drive_op(1'b0, 1'b0, 3'b011, 64'h8000_0000, 64'h0, 5'd5);
        @(negedge clock);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL noop_valid got=%0h exp=1", out_valid); end
        checks++; if (out_rdata !== 64'h0) begin failures++; $display("[TB] FAIL noop_rdata got=%0h exp=0", out_rdata); end
        checks++; if (out_rd !== 5'd5) begin failures++; $display("[TB] FAIL noop_rd got=%0d exp=5", out_rd); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        mem_rdata = 64'hCAFE_F00D_1234_5678;
        out_ready = 1'b0;
        drive_op(1'b1, 1'b0, 3'b011, 64'h8000_0010, 64'h0, 5'd3);
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        mem_rdata = 64'h0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clock);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp%0d_valid got=%0h exp=1", c, out_valid); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp%0d_in_ready got=%0h exp=0", c, in_ready); end
            checks++; if (out_rdata !== 64'hCAFE_F00D_1234_5678) begin failures++; $display("[TB] FAIL bp%0d_rdata got=%0h exp=cafef00d12345678", c, out_rdata); end
            checks++; if (out_rd !== 5'd3) begin failures++; $display("[TB] FAIL bp%0d_rd got=%0d exp=3", c, out_rd); end
        end
        out_ready = 1'b1;
        drive_op(1'b0, 1'b1, 3'b011, 64'h8000_0020, 64'h0123_4567_89AB_CDEF, 5'd9);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_in_ready got=%0h exp=1", in_ready); end
        @(negedge clock);
        in_valid = 1'b0;
        checks++; if (mem_wen !== 1'b1) begin failures++; $display("[TB] FAIL b2b_wen got=%0h exp=1", mem_wen); end
        checks++; if (mem_wmask !== 8'hFF) begin failures++; $display("[TB] FAIL b2b_wmask got=%0h exp=ff", mem_wmask); end
        checks++; if (mem_waddr !== 64'h8000_0020) begin failures++; $display("[TB] FAIL b2b_waddr got=%0h exp=80000020", mem_waddr); end
        checks++; if (mem_wdata !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("[TB] FAIL b2b_wdata got=%0h exp=0123456789abcdef", mem_wdata); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_valid_access got=%0h exp=0", out_valid); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid_done got=%0h exp=1", out_valid); end
        checks++; if (out_rd !== 5'd9) begin failures++; $display("[TB] FAIL b2b_rd got=%0d exp=9", out_rd); end
        checks++; if (out_rdata !== 64'h0) begin failures++; $display("[TB] FAIL b2b_rdata got=%0h exp=0", out_rdata); end
        @(negedge clock);
    endtask

    task automatic test_reset_in_access();
        drive_op(1'b0, 1'b1, 3'b011, 64'h8000_0040, 64'hDEAD_BEEF_DEAD_BEEF, 5'd6);
        @(negedge clock);
        in_valid = 1'b0;
        checks++; if (mem_wen !== 1'b1) begin failures++; $display("[TB] FAIL rst_pre_wen got=%0h exp=1", mem_wen); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (mem_wen !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_wen got=%0h exp=0", mem_wen); end
        checks++; if (mem_wmask !== 8'h00) begin failures++; $display("[TB] FAIL rst_async_wmask got=%0h exp=0", mem_wmask); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_valid got=%0h exp=0", out_valid); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_post_in_ready got=%0h exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_post_valid got=%0h exp=0", out_valid); end
        checks++; if (mem_wen !== 1'b0) begin failures++; $display("[TB] FAIL rst_post_wen got=%0h exp=0", mem_wen); end
        checks++; if (mem_waddr !== 64'h0) begin failures++; $display("[TB] FAIL rst_post_waddr got=%0h exp=0", mem_waddr); end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_extend();
        test_load_double();
        test_misaligned();
        test_no_op();
        test_back_to_back();
        test_reset_in_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store unit sitting directly upstream of the DPI-backed memory model. It accepts one memory op at a time from the execute stage over a valid/ready handshake.
- It drives the memory model's read/write address, data, mask and write-enable. It then aligns and sign/zero-extends load data and hands the result to write-back over a second valid/ready handshake.
- The memory model is combinational; this block supplies all sequencing.

Parameters:
- XLEN, 64, data/address width
- RD_W, 5, destination register index width

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage presents an op
- in_ready  out  1  block can accept an op
- in_is_load  in  1  op is a load
- in_is_store  in  1  op is a store; load and store are never both set
- in_funct3  in  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- in_addr  in  XLEN  byte address
- in_wdata  in  XLEN  store data, right-justified
- in_rd  in  RD_W  destination register index
- mem_raddr  out  XLEN  read address to memory model, 8-byte aligned
- mem_ren  out  1  read enable
- mem_rdata  in  XLEN  read data, combinational from mem_raddr
- mem_waddr  out  XLEN  write address, 8-byte aligned
- mem_wdata  out  XLEN  lane-shifted write data
- mem_wmask  out  8  byte-lane write mask
- mem_wen  out  1  write enable
- out_valid  out  1  result available
- out_ready  in  1  write-back accepts result
- out_rdata  out  XLEN  extended load data; 0 for stores
- out_rd  out  RD_W  latched in_rd
- out_misalign  out  1  access was misaligned and was suppressed

Behaviour:
- Clock and reset: one clock, `clock`; reset is `reset_n`, asynchronous and active-low. Reset forces state IDLE and clears every holding register. While reset is low:
  - out_valid=0, mem_ren=0, mem_wen=0, mem_wmask=0.
  - All data outputs are 0.
  - in_ready=1.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch funct3, addr, wdata, rd and op type, then go to ACCESS.
  - An op with neither load nor store set goes straight to DONE with out_rdata=0.
- ACCESS (exactly one cycle):
  - Load: mem_ren=1, mem_raddr={addr[63:3],3'b000}; mem_rdata is captured into the data register at the clock edge.
  - Store: mem_wen=1 for exactly this one cycle, with:
    - mem_waddr = aligned address
    - mem_wmask = size mask (B 0x01, H 0x03, W 0x0F, D 0xFF) << addr[2:0]
    - mem_wdata = wdata << (8*addr[2:0])
  - Always go to DONE.
- DONE:
  - out_valid=1.
  - out_rdata = (captured >> 8*addr[2:0]), truncated to the access size. Signed codes sign-extend; codes 1xx zero-extend.
  - out_rd, out_rdata and out_misalign stay stable until the handshake completes.
  - On out_ready, go to IDLE, or directly to ACCESS if in_valid is also high. in_ready = IDLE | (DONE & out_ready).
- Outside ACCESS, mem_ren=0, mem_wen=0 and mem_wmask=0. The address and data outputs hold their last values.
- Misalignment:
  - Defined as addr not a multiple of the access size (H addr[0]≠0, W addr[1:0]≠0, D addr[2:0]≠0).
  - Detected at acceptance. ACCESS still occurs, but mem_ren and mem_wen stay 0.
  - In DONE: out_misalign=1 and out_rdata=0.
- funct3 code 111 is treated as misaligned (illegal).
- Latency: accept to out_valid is 2 cycles; peak throughput is one op per 2 cycles.
- Reset asserted in ACCESS: mem_wen deasserts immediately (async) and no partial write survives.

Decomposition:
- Shared package lsu_pkg:
  - state enum (IDLE/ACCESS/DONE)
  - funct3 localparams (F3_B … F3_WU)
  - function size_mask(funct3) returning the 8-bit mask
- One natural sub-module: lsu_load_align, combinational. Takes captured data, addr[2:0] and funct3; outputs the extended XLEN result. It is reusable by a future cache path.

Test Plan:
- SB, addr 0x80000003, wdata 0xAB → in ACCESS: mem_waddr 0x80000000, mem_wmask 0x08, mem_wdata 0x00000000AB000000, mem_wen high exactly one cycle. Then out_valid with out_rdata 0.
- LB / LBU, addr 0x80000005, mem_rdata 0x0000800000000000 → LB out_rdata 0xFFFFFFFFFFFFFF80; LBU out_rdata 0x0000000000000080. out_valid 2 cycles after acceptance.
- LD, addr 0x80000008, mem_rdata 0x1122334455667788, rd 7 → out_rdata 0x1122334455667788, out_rd 7, out_misalign 0.
- LW, addr 0x80000006 → mem_ren and mem_wen never asserted; out_misalign 1; out_rdata 0.
- Backpressure: out_ready held low 3 cycles in DONE → outputs stable, in_ready 0. Then out_ready=1 with in_valid=1 → next op accepted the same cycle, and ACCESS follows the next cycle.
- SD accepted, reset_n pulled low during ACCESS → mem_wen drops asynchronously, state IDLE, out_valid 0, in_ready 1 after release.
